// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encodings, grantee identifiers and small helpers.
package mem_port_arbiter_pkg;

  // Arbiter FSM states
  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_DONE  = 2'd3;

  // Grantee identifiers
  localparam logic ARB_GNT_I = 1'b0;
  localparam logic ARB_GNT_D = 1'b1;

  // Width of the streak and latency counters
  localparam int unsigned CNT_W = 4;

  // Saturating increment for the 4-bit data-streak counter
  function automatic logic [CNT_W-1:0] sat_inc4(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker: data wins unless an instruction request has
// already been passed over D_STREAK_MAX times in a row.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned D_STREAK_MAX = 4
) (
  input  logic             i_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] streak,
  output logic             grant_valid,
  output logic             grant_id
);

  logic d_allowed;

  // Data may go first only while the instruction port is not starved
  always_comb begin
    d_allowed   = d_req & (~i_req | (streak < D_STREAK_MAX[CNT_W-1:0]));
    grant_valid = i_req | d_req;
    grant_id    = d_allowed ? ARB_GNT_D : ARB_GNT_I;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data ports.
// One transaction at a time: IDLE arbitrates and latches the request, ISSUE
// strobes the memory, WAIT covers the read latency, DONE pulses ready.
// Optional perf counters (conflict_cnt, stall_cnt) when MEM_ARB_PERF_CNT_EN
// is defined.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned D_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] streak;
  logic             gnt_id;
  logic             lat_wen;
  logic             grant_valid;
  logic             grant_id;
  logic             take_grant;
  logic             capture;
  logic             finish;

  mem_arb_pick #(
    .D_STREAK_MAX(D_STREAK_MAX)
  ) u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .streak     (streak),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  assign cpu_stall = (i_req & ~i_ready) | (d_req & ~d_ready);

  // Decode the cycles that start, finish and capture a transaction
  always_comb begin
    take_grant = (state == ARB_IDLE) & grant_valid;
    capture    = (state == ARB_WAIT) & (cnt == '0);
    finish     = ((state == ARB_ISSUE) & lat_wen) | capture;
  end

  // State register and read-latency down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (grant_valid) state <= ARB_ISSUE;
        end
        ARB_ISSUE: begin
          if (lat_wen) begin
            state <= ARB_DONE;
          end else begin
            state <= ARB_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        ARB_WAIT: begin
          if (cnt == '0) state <= ARB_DONE;
          else           cnt   <= cnt - 4'd1;
        end
        ARB_DONE: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  // Grant bookkeeping: grantee, starvation streak and the latched request.
  // mem_addr/mem_wdata double as the latch so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_id    <= ARB_GNT_I;
      lat_wen   <= 1'b0;
      streak    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (take_grant) begin
      gnt_id <= grant_id;
      if (grant_id == ARB_GNT_D) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        lat_wen   <= d_wen;
        streak    <= i_req ? sat_inc4(streak) : '0;
      end else begin
        mem_addr  <= i_addr;
        mem_wdata <= '0;
        lat_wen   <= 1'b0;
        streak    <= '0;
      end
    end
  end

  // Memory strobes: high for exactly the ISSUE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en  <= 1'b0;
      mem_wen <= 1'b0;
    end else begin
      mem_en  <= take_grant;
      mem_wen <= take_grant & (grant_id == ARB_GNT_D) & d_wen;
    end
  end

  // Completion pulses: high for exactly the DONE cycle, grantee only
  always_ff @(posedge clk) begin
    if (rst) begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
    end else begin
      i_ready <= finish & (gnt_id == ARB_GNT_I);
      d_ready <= finish & (gnt_id == ARB_GNT_D);
    end
  end

  // Read data captured on the last WAIT cycle and held until the next read
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else if (capture) begin
      if (gnt_id == ARB_GNT_D) d_rdata <= mem_rdata;
      else                     i_rdata <= mem_rdata;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  // Count arbitration conflicts and pipeline stall cycles (wrapping)
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if ((state == ARB_IDLE) & i_req & d_req) conflict_cnt <= conflict_cnt + 32'd1;
      if (cpu_stall)                           stall_cnt    <= stall_cnt + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration
`endif

endmodule
